// File: rtl/alu_issue_if.sv
// Request, ALU-side and response signals of the single-issue ALU front end.
// The slave modport is the issue unit; the master modport is its environment.
interface alu_issue_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [3:0]   cond;
    logic         set_flags;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_result;
    logic         alu_z;
    logic         alu_n;
    logic         alu_v;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_exec;
    logic         out_wb;
    logic         out_err;
    logic [2:0]   flags;

    modport slave (
        input  in_valid, op, cond, set_flags, a_in, b_in,
        input  alu_result, alu_z, alu_n, alu_v, out_ready,
        output in_ready, alu_a, alu_b, alu_sel,
        output out_valid, out_result, out_exec, out_wb, out_err, flags
    );

    modport master (
        output in_valid, op, cond, set_flags, a_in, b_in,
        output alu_result, alu_z, alu_n, alu_v, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel,
        input  out_valid, out_result, out_exec, out_wb, out_err, flags
    );
endinterface

// File: rtl/alu_issue.sv
// Single-issue ALU front end: accept, one EXEC cycle, hold response.
// Conditions are checked against the NZV flag register at accept time.
module alu_issue #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [3:0]   r_alu_sel;
    logic [3:0]   r_op;
    logic         r_sf;
    logic         r_ok;
    logic         r_ill;
    logic [N-1:0] r_out_result;
    logic         r_out_exec;
    logic         r_out_wb;
    logic         r_out_err;
    logic [2:0]   r_flags;
    logic         w_accept;
    logic         w_legal;
    logic         w_cond_ok;
    logic [3:0]   w_sel;
    logic         w_upd;
    logic         w_arith;

    assign w_accept = (r_state == S_IDLE) & bus.in_valid;
    assign w_legal  = (bus.op <= 4'd8);
    assign w_arith  = (r_op <= 4'd2);
    assign w_upd    = r_ok & (r_sf | (r_op == 4'd2));

    // flags are {N,Z,V}
    always_comb begin
        w_cond_ok = 1'b0;
        case (bus.cond)
            4'd0:    w_cond_ok = r_flags[1];
            4'd1:    w_cond_ok = ~r_flags[1];
            4'd2:    w_cond_ok = r_flags[2];
            4'd3:    w_cond_ok = ~r_flags[2];
            4'd4:    w_cond_ok = r_flags[0];
            4'd5:    w_cond_ok = ~r_flags[0];
            4'd14:   w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_sel = 4'd0;
        case (bus.op)
            4'd0:       w_sel = 4'd1;
            4'd1, 4'd2: w_sel = 4'd2;
            4'd3, 4'd4, 4'd5, 4'd6,
            4'd7, 4'd8: w_sel = bus.op;
            default:    w_sel = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= 4'd0;
            r_op         <= 4'd0;
            r_sf         <= 1'b0;
            r_ok         <= 1'b0;
            r_ill        <= 1'b0;
            r_out_result <= '0;
            r_out_exec   <= 1'b0;
            r_out_wb     <= 1'b0;
            r_out_err    <= 1'b0;
            r_flags      <= 3'b000;
        end else if (w_accept) begin
            r_alu_a   <= bus.a_in;
            r_alu_b   <= bus.b_in;
            r_alu_sel <= (w_legal & w_cond_ok) ? w_sel : 4'd0;
            r_op      <= bus.op;
            r_sf      <= bus.set_flags;
            r_ok      <= w_legal & w_cond_ok;
            r_ill     <= ~w_legal;
        end else if (r_state == S_EXEC) begin
            r_out_result <= r_ok ? bus.alu_result : '0;
            r_out_exec   <= r_ok;
            r_out_wb     <= r_ok & (r_op != 4'd2);
            r_out_err    <= r_ill;
            // V only tracks add/sub overflow; logic ops leave it alone
            if (w_upd)
                r_flags <= {bus.alu_n, bus.alu_z,
                            w_arith ? bus.alu_v : r_flags[0]};
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_RESP);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_sel    = r_alu_sel;
    assign bus.out_result = r_out_result;
    assign bus.out_exec   = r_out_exec;
    assign bus.out_wb     = r_out_wb;
    assign bus.out_err    = r_out_err;
    assign bus.flags      = r_flags;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, reference model, directed
// corner cases and a randomized run with occasional async reset.
module tb_alu_issue;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.N(N)) bus();

    alu_issue #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // environment ALU driven by the registered select/operands
    logic [N:0]   alu_s;
    logic [N-1:0] alu_r;
    logic         alu_ov;
    always_comb begin
        alu_s  = '0;
        alu_r  = '0;
        alu_ov = 1'b0;
        case (bus.alu_sel)
            4'd1: begin
                alu_s  = {bus.alu_a[N-1], bus.alu_a} + {bus.alu_b[N-1], bus.alu_b};
                alu_r  = alu_s[N-1:0];
                alu_ov = alu_s[N] ^ alu_s[N-1];
            end
            4'd2: begin
                alu_s  = {bus.alu_a[N-1], bus.alu_a} - {bus.alu_b[N-1], bus.alu_b};
                alu_r  = alu_s[N-1:0];
                alu_ov = alu_s[N] ^ alu_s[N-1];
            end
            4'd3:    alu_r = bus.alu_a << bus.alu_b;
            4'd4:    alu_r = bus.alu_a >> bus.alu_b;
            4'd5:    alu_r = bus.alu_a & bus.alu_b;
            4'd6:    alu_r = bus.alu_a | bus.alu_b;
            4'd7:    alu_r = bus.alu_b;
            4'd8:    alu_r = bus.alu_a;
            default: alu_r = '0;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_z      = (alu_r == '0);
    assign bus.alu_n      = alu_r[N-1];
    assign bus.alu_v      = alu_ov;

    function automatic logic [N-1:0] spec_result(logic [3:0] op,
                                                 logic [N-1:0] a,
                                                 logic [N-1:0] b);
        case (op)
            4'd0:       return a + b;
            4'd1, 4'd2: return a - b;
            4'd3:       return a << b;
            4'd4:       return a >> b;
            4'd5:       return a & b;
            4'd6:       return a | b;
            4'd7:       return b;
            4'd8:       return a;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [2:0] spec_flags(logic [3:0] op,
                                              logic [N-1:0] a,
                                              logic [N-1:0] b,
                                              logic [2:0] old);
        logic [N-1:0] r;
        logic v;
        r = spec_result(op, a, b);
        v = old[0];
        if (op == 4'd0)
            v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        else if (op == 4'd1 || op == 4'd2)
            v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
        return {r[N-1], r == '0, v};
    endfunction

    function automatic logic cond_pass(logic [3:0] c, logic [2:0] f);
        case (c)
            4'd0:    return f[1];
            4'd1:    return !f[1];
            4'd2:    return f[2];
            4'd3:    return !f[2];
            4'd4:    return f[0];
            4'd5:    return !f[0];
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] spec_sel(logic [3:0] op);
        if (op == 4'd0) return 4'd1;
        if (op <= 4'd2) return 4'd2;
        if (op <= 4'd8) return op;
        return 4'd0;
    endfunction

    // reference model: phase 0 idle, 1 executing, 2 responding
    int           m_ph = 0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    logic [3:0]   m_sel = '0;
    logic [N-1:0] m_res = '0;
    logic         m_exec = 1'b0;
    logic         m_wb = 1'b0;
    logic         m_err = 1'b0;
    logic [2:0]   m_flags = '0;
    logic [3:0]   p_op = '0;
    logic         p_sf = 1'b0;
    logic         p_ok = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_a <= '0; m_b <= '0; m_sel <= '0;
            m_res <= '0; m_exec <= 1'b0; m_wb <= 1'b0;
            m_err <= 1'b0; m_flags <= '0; p_ok <= 1'b0;
        end else if (m_ph == 0) begin
            if (bus.in_valid) begin
                m_ph  <= 1;
                m_a   <= bus.a_in;
                m_b   <= bus.b_in;
                p_op  <= bus.op;
                p_sf  <= bus.set_flags;
                p_ok  <= (bus.op <= 4'd8) && cond_pass(bus.cond, m_flags);
                m_sel <= ((bus.op <= 4'd8) && cond_pass(bus.cond, m_flags))
                         ? spec_sel(bus.op) : 4'd0;
            end
        end else if (m_ph == 1) begin
            m_ph   <= 2;
            m_res  <= p_ok ? spec_result(p_op, m_a, m_b) : '0;
            m_exec <= p_ok;
            m_wb   <= p_ok && (p_op != 4'd2);
            m_err  <= (p_op > 4'd8);
            if (p_ok && (p_sf || p_op == 4'd2))
                m_flags <= spec_flags(p_op, m_a, m_b, m_flags);
        end else begin
            if (bus.out_ready) m_ph <= 0;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic cmp(string name, logic [N-1:0] act, logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_ready", N'(bus.in_ready), N'(m_ph == 0));
            cmp("out_valid", N'(bus.out_valid), N'(m_ph == 2));
            cmp("flags", N'(bus.flags), N'(m_flags));
            cmp("alu_a", bus.alu_a, m_a);
            cmp("alu_b", bus.alu_b, m_b);
            cmp("alu_sel", N'(bus.alu_sel), N'(m_sel));
            if (m_ph == 2) begin
                cmp("out_result", bus.out_result, m_res);
                cmp("out_exec", N'(bus.out_exec), N'(m_exec));
                cmp("out_wb", N'(bus.out_wb), N'(m_wb));
                cmp("out_err", N'(bus.out_err), N'(m_err));
            end
        end
    end

    logic [3:0]   s_sel;
    logic [N-1:0] s_res;
    logic         s_exec, s_wb, s_err;
    logic [2:0]   s_flags;

    task automatic run_op(logic [3:0] op, logic [3:0] cond, logic sf,
                          logic [N-1:0] a, logic [N-1:0] b, int hold);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) cmp("idle_timeout", N'(bus.in_ready), N'(1));
        bus.in_valid = 1'b1; bus.op = op; bus.cond = cond;
        bus.set_flags = sf; bus.a_in = a; bus.b_in = b;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        s_sel = bus.alu_sel;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) cmp("resp_timeout", N'(bus.out_valid), N'(1));
        s_res = bus.out_result; s_exec = bus.out_exec;
        s_wb = bus.out_wb; s_err = bus.out_err;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.op = 4'd8; bus.cond = 4'd14;
            bus.set_flags = 1'b1; bus.a_in = $urandom; bus.b_in = $urandom;
            @(negedge clk);
            cmp("hold_result", bus.out_result, s_res);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        s_flags = bus.flags;
    endtask

    logic [3:0] conds [9];

    initial begin
        conds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd14, 4'd14, 4'd9};
        bus.in_valid = 1'b0; bus.op = '0; bus.cond = '0;
        bus.set_flags = 1'b0; bus.a_in = '0; bus.b_in = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_in_ready", N'(bus.in_ready), N'(1));
        cmp("rst_flags", N'(bus.flags), N'(0));
        #2 rst_n = 1'b1;

        run_op(4'd0, 4'd14, 1'b1, 32'h7FFF_FFFF, 32'h1, 0);
        cmp("add_sel", N'(s_sel), N'(1));
        cmp("add_res", s_res, 32'h8000_0000);
        cmp("add_exec_wb", N'({s_exec, s_wb}), N'(2'b11));
        cmp("add_flags", N'(s_flags), N'(3'b101));
        cmp("model_add_flags", N'(m_flags), N'(3'b101));

        run_op(4'd2, 4'd14, 1'b0, 32'd5, 32'd5, 0);
        cmp("cmp_wb", N'(s_wb), N'(0));
        cmp("cmp_flags", N'(s_flags), N'(3'b010));

        run_op(4'd1, 4'd0, 1'b0, 32'd9, 32'd4, 0);
        cmp("subeq_exec", N'(s_exec), N'(1));
        cmp("subeq_res", s_res, 32'd5);
        cmp("model_subeq_res", m_res, 32'd5);

        run_op(4'd1, 4'd1, 1'b1, 32'd9, 32'd4, 0);
        cmp("subne_sel", N'(s_sel), N'(0));
        cmp("subne_exec", N'(s_exec), N'(0));
        cmp("subne_res", s_res, 32'd0);
        cmp("subne_flags", N'(s_flags), N'(3'b010));

        run_op(4'd12, 4'd14, 1'b1, 32'd3, 32'd3, 0);
        cmp("ill_err", N'(s_err), N'(1));
        cmp("ill_exec", N'(s_exec), N'(0));
        cmp("ill_flags", N'(s_flags), N'(3'b010));

        run_op(4'd0, 4'd14, 1'b1, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(4'd3, 4'd14, 1'b1, 32'd1, 32'd4, 0);
        cmp("lsl_res", s_res, 32'h10);
        cmp("lsl_flags", N'(s_flags), N'(3'b001));

        run_op(4'd6, 4'd14, 1'b0, 32'hF0, 32'h0F, 5);
        cmp("orr_res", s_res, 32'hFF);

        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.cond = 4'd14;
        bus.set_flags = 1'b1; bus.a_in = 32'h7FFF_FFFF; bus.b_in = 32'h1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_out_valid", N'(bus.out_valid), N'(0));
        cmp("rst_sel", N'(bus.alu_sel), N'(0));
        cmp("rst_a", bus.alu_a, 32'd0);
        cmp("rst_flags2", N'(bus.flags), N'(0));
        cmp("rst_ready", N'(bus.in_ready), N'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        cmp("post_rst_valid", N'(bus.out_valid), N'(0));

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom % 2) == 0;
            bus.op        = ($urandom % 4 != 0) ? 4'($urandom % 9) : 4'($urandom);
            bus.cond      = conds[$urandom % 9];
            bus.set_flags = $urandom % 2;
            bus.a_in      = ($urandom % 3 == 0) ? 32'($urandom % 8) : $urandom;
            bus.b_in      = ($urandom % 2 == 0) ? 32'($urandom % 40) : $urandom;
            bus.out_ready = ($urandom % 10) < 7;
            if ($urandom % 300 == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: N, 32, operand/result width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when in_valid & in_ready at rising edge.
REQ-006 op  input  4  0 ADD, 1 SUB, 2 CMP, 3 LSL, 4 LSR, 5 AND, 6 ORR, 7 MOV(b), 8 PASS(a), 9-15 illegal.
REQ-007 cond  input  4  0 EQ, 1 NE, 2 MI, 3 PL, 4 VS, 5 VC, 14 AL, all others never.
REQ-008 set_flags  input  1  update NZV flags on executed op.
REQ-009 a_in, b_in  input  N  operands.
REQ-010 alu_a, alu_b  output  N  registered operands to the ALU.
REQ-011 alu_sel  output  4  registered ALU select: 0 zero, 1 add, 2 sub, 3 shl, 4 shr, 5 and, 6 or, 7 pass b, 8 pass a.
REQ-012 alu_result  input  N; alu_z, alu_n, alu_v  input  1 each  combinational ALU outputs.
REQ-013 out_valid  output  1; out_ready  input  1  response handshake.
REQ-014 out_result  output  N  captured result.
REQ-015 out_exec  output  1  condition passed and op legal; out_wb  output  1  result to be written back; out_err  output  1  illegal op.
REQ-016 flags  output  3  {N,Z,V} architectural flag register.

Function
REQ-017 FSM states IDLE, EXEC, RESP; in_ready = 1 only in IDLE.
REQ-018 IDLE: on accept, register a_in->alu_a, b_in->alu_b, op, cond, set_flags; alu_sel = op mapping (ADD->1, SUB->2, CMP->2, LSL->3, LSR->4, AND->5, ORR->6, MOV->7, PASS->8); go EXEC.
REQ-019 Illegal op or failed cond: alu_sel registered as 0.
REQ-020 Cond evaluated against flags register at accept edge: EQ Z=1, NE Z=0, MI N=1, PL N=0, VS V=1, VC V=0, AL 1, else 0.
REQ-021 EXEC lasts exactly one cycle; at its closing edge capture out_result = alu_result if out_exec else 0; set out_exec, out_wb, out_err; go RESP.
REQ-022 out_wb = out_exec & (op != CMP).
REQ-023 Flags update at EXEC closing edge only if out_exec & (set_flags | op==CMP): N<=alu_n, Z<=alu_z; V<=alu_v for ADD/SUB/CMP, V unchanged for other ops.
REQ-024 Failed cond or illegal op: flags unchanged.
REQ-025 RESP: out_valid=1, out_* held stable until out_valid & out_ready edge; then go IDLE, out_valid=0.
REQ-026 Latency: accept edge E0, out_valid high after E0+2 edges; max throughput one op per 3 cycles with out_ready tied high.
REQ-027 in_valid while not IDLE ignored; no queuing.
REQ-028 out_ready high in IDLE/EXEC has no effect.
REQ-029 Flag update of op k visible to cond of op k+1 (accept after RESP).

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, in_ready 1, out_valid 0, out_result 0, out_exec/out_wb/out_err 0, alu_a/alu_b 0, alu_sel 0, flags 000.
REQ-031 Reset mid-EXEC or mid-RESP discards the transaction; no flag update, no response after release.
REQ-032 First accept possible at first rising edge after rst_n high.

Verification
REQ-033 ADD AL set_flags, a=0x7FFFFFFF, b=1 -> alu_sel 1, out_result 0x80000000, out_exec 1, out_wb 1, flags N=1 Z=0 V=1.
REQ-034 CMP AL a=5, b=5 then SUB EQ a=9, b=4 -> CMP: out_wb 0, Z=1; SUB: out_exec 1, out_result 5.
REQ-035 SUB NE after Z=1 -> alu_sel 0, out_exec 0, out_result 0, flags unchanged.
REQ-036 op 12 -> out_err 1, out_exec 0, flags unchanged; LSL a=1, b=4 set_flags -> result 0x10, V unchanged.
REQ-037 out_ready held low 5 cycles in RESP -> out_valid and out_result stable, in_ready 0, new in_valid ignored.
REQ-038 rst_n low during EXEC of ADD set_flags -> all outputs reset values immediately, flags 000, no out_valid after release.
